// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the cpu_mem data port: fixed m0 priority with a
// starvation counter that forces one m1 grant; single-cycle response pipeline.
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    DT_BYTE = 2'd0,
    DT_HALF = 2'd1,
    DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [2:0] {
    ENONE  = 3'd0,
    EALIGN = 3'd1,
    EBUS   = 3'd2
  } errno_e;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wd,
  input  mem_dt_e     m0_dt,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  output errno_e      m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wd,
  input  mem_dt_e     m1_dt,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  output errno_e      m1_err,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  output mem_dt_e     mem_dt,
  input  logic [31:0] mem_rd,
  input  errno_e      mem_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_m1;
  logic             m0_win;
  logic             m1_win;
  logic             resp_live;

  // Arbitration and request mux; grants are held off while in reset.
  always_comb begin
    force_m1 = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT);
    m1_win   = !rst && m1_req && (!m0_req || force_m1);
    m0_win   = !rst && m0_req && !m1_win;
    m0_gnt   = m0_win;
    m1_gnt   = m1_win;
    mem_en   = m0_win | m1_win;
    if (m1_win) begin
      mem_addr = m1_addr;
      mem_we   = m1_we;
      mem_wd   = m1_wd;
      mem_dt   = m1_dt;
    end else if (m0_win) begin
      mem_addr = m0_addr;
      mem_we   = m0_we;
      mem_wd   = m0_wd;
      mem_dt   = m0_dt;
    end else begin
      mem_addr = 32'h0;
      mem_we   = 1'b0;
      mem_wd   = 32'h0;
      mem_dt   = DT_WORD;
    end
  end

  // Next-state: starvation counter, response owner and pipeline state.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (m1_req && !m1_win) begin
      if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = {CNT_W{1'b0}};
    end

    owner_d = m1_win;
    we_d    = mem_we;
    case (state_q)
      IDLE:    state_d = mem_en ? RESP : IDLE;
      RESP:    state_d = mem_en ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response steering: only the owner of the pending access sees memory data.
  always_comb begin
    resp_live = (state_q == RESP) && !rst;
    m0_rvalid = resp_live && !owner_q;
    m1_rvalid = resp_live && owner_q;
    if (m0_rvalid) begin
      m0_rd  = we_q ? 32'h0 : mem_rd;
      m0_err = mem_err;
    end else begin
      m0_rd  = 32'h0;
      m0_err = ENONE;
    end
    if (m1_rvalid) begin
      m1_rd  = we_q ? 32'h0 : mem_rd;
      m1_err = mem_err;
    end else begin
      m1_rd  = 32'h0;
      m1_err = ENONE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a small memory model answers mem_en
// one cycle later; expected responses are queued when stimulus is driven.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] rd;
    errno_e      err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  mem_dt_e     m0_dt, m1_dt;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rd, m1_rd;
  errno_e      m0_err, m1_err;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wd;
  mem_dt_e     mem_dt;
  logic [31:0] mem_rd;
  errno_e      mem_err;

  logic        z_m0_gnt, z_m0_rvalid, z_m1_gnt, z_m1_rvalid, z_mem_en, z_mem_we;
  logic [31:0] z_m0_rd, z_m1_rd, z_mem_addr, z_mem_wd;
  errno_e      z_m0_err, z_m1_err;
  mem_dt_e     z_mem_dt;

  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd), .m0_dt(m0_dt),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd), .m1_dt(m1_dt),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd), .m1_err(m1_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_dt(mem_dt),
    .mem_rd(mem_rd), .mem_err(mem_err)
  );

  // Strict-priority instance sharing the request inputs.
  dmem_arbiter #(.STARVE_LIMIT(0), .CNT_W(4)) dut_strict (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd), .m0_dt(m0_dt),
    .m0_gnt(z_m0_gnt), .m0_rvalid(z_m0_rvalid), .m0_rd(z_m0_rd), .m0_err(z_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd), .m1_dt(m1_dt),
    .m1_gnt(z_m1_gnt), .m1_rvalid(z_m1_rvalid), .m1_rd(z_m1_rd), .m1_err(z_m1_err),
    .mem_en(z_mem_en), .mem_addr(z_mem_addr), .mem_we(z_mem_we), .mem_wd(z_mem_wd),
    .mem_dt(z_mem_dt), .mem_rd(32'h0), .mem_err(ENONE)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word storage, 1-cycle read latency, alignment errors.
  always @(posedge clk) begin
    mem_rd  <= 32'h0;
    mem_err <= ENONE;
    if (rst) begin
      mem[8'h80] <= 32'habcdef12;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wd;
      else        mem_rd <= mem[mem_addr[9:2]];
      if ((mem_dt == DT_HALF && mem_addr[0]) || (mem_dt == DT_WORD && mem_addr[1:0] != 2'b00))
        mem_err <= EALIGN;
    end
  end

  // Response monitor: pops the scoreboard when an entry falls due.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_checks++;
      if ({m0_rvalid, m1_rvalid} !== {~e.owner, e.owner}) begin
        n_fail++;
        $display("FAIL resp_valid cyc=%0d: got m0/m1=%b%b, want %b%b", cyc, m0_rvalid, m1_rvalid, ~e.owner, e.owner);
      end
      n_checks++;
      if ((e.owner ? m1_rd : m0_rd) !== e.rd) begin
        n_fail++;
        $display("FAIL resp_rd m%0d cyc=%0d: got %h, want %h", e.owner, cyc, e.owner ? m1_rd : m0_rd, e.rd);
      end
      n_checks++;
      if ((e.owner ? m1_err : m0_err) !== e.err) begin
        n_fail++;
        $display("FAIL resp_err m%0d cyc=%0d: got %0d, want %0d", e.owner, cyc, e.owner ? m1_err : m0_err, e.err);
      end
    end else if (m0_rvalid || m1_rvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_rvalid cyc=%0d: got m0/m1=%b%b, want 00", cyc, m0_rvalid, m1_rvalid);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wd = 32'h0; m0_dt = DT_WORD;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wd = 32'h0; m1_dt = DT_WORD;
  endtask

  task automatic push_exp(input logic owner, input logic [31:0] rd, input errno_e err);
    exp_t e;
    e.due = cyc + 1; e.owner = owner; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_wd = 32'hdeadbeef;
    m1_req = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt: got gnt0/gnt1/en/we=%b, want 0000", {m0_gnt, m1_gnt, mem_en, mem_we});
    end
    n_checks++;
    if ({m0_rvalid, m1_rvalid, m0_rd, m1_rd, m0_err, m1_err} !== {2'b00, 64'h0, ENONE, ENONE}) begin
      n_fail++;
      $display("FAIL reset_resp: got rv=%b%b rd=%h/%h err=%0d/%0d, want 00 0/0 0/0",
               m0_rvalid, m1_rvalid, m0_rd, m1_rd, m0_err, m1_err);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_m1_read();
    m1_req = 1'b1; m1_addr = 32'h200; m1_dt = DT_WORD;
    push_exp(1'b1, 32'habcdef12, ENONE);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b0110 || mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL m1_read_gnt: got gnt0/gnt1/en/we=%b addr=%h, want 0110 addr=200",
               {m0_gnt, m1_gnt, mem_en, mem_we}, mem_addr);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_then_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wd = 32'h12345678; m0_dt = DT_WORD;
    push_exp(1'b0, 32'h0, ENONE);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we} !== 3'b101 || mem_wd !== 32'h12345678 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL m0_write_gnt: got gnt0/gnt1/we=%b wd=%h addr=%h, want 101 12345678 100",
               {m0_gnt, m1_gnt, mem_we}, mem_wd, mem_addr);
    end
    next_cycle();
    idle_inputs();
    m1_req = 1'b1; m1_addr = 32'h100; m1_dt = DT_WORD;
    push_exp(1'b1, 32'h12345678, ENONE);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we} !== 3'b010) begin
      n_fail++;
      $display("FAIL m1_read_after_write_gnt: got gnt0/gnt1/we=%b, want 010", {m0_gnt, m1_gnt, mem_we});
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  // Both masters request every cycle: m1 wins every 9th cycle (limit 8),
  // never on the strict instance.
  task automatic test_back_to_back(input int ncyc);
    logic want_m1;
    m0_req = 1'b1; m0_addr = 32'h200; m0_dt = DT_WORD;
    m1_req = 1'b1; m1_addr = 32'h100; m1_dt = DT_WORD;
    for (int i = 0; i < ncyc; i++) begin
      want_m1 = ((i % 9) == 8);
      if (want_m1) push_exp(1'b1, 32'h12345678, ENONE);
      else         push_exp(1'b0, 32'habcdef12, ENONE);
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {~want_m1, want_m1}) begin
        n_fail++;
        $display("FAIL starve_gnt i=%0d: got gnt0/gnt1=%b%b, want %b%b", i, m0_gnt, m1_gnt, ~want_m1, want_m1);
      end
      n_checks++;
      if ({z_m0_gnt, z_m1_gnt} !== 2'b10) begin
        n_fail++;
        $display("FAIL strict_gnt i=%0d: got gnt0/gnt1=%b%b, want 10", i, z_m0_gnt, z_m1_gnt);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_pending();
    m0_req = 1'b1; m0_addr = 32'h200; m1_req = 1'b1; m1_addr = 32'h100;
    for (int i = 0; i < 5; i++) begin
      push_exp(1'b0, 32'habcdef12, ENONE);
      next_cycle();
    end
    m1_req = 1'b0;
    next_cycle();
    // m0 read granted in the previous cycle; its response must be dropped.
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m0_rd, m0_err} !== {1'b0, 32'h0, ENONE}) begin
      n_fail++;
      $display("FAIL reset_pending: got rv=%b rd=%h err=%0d, want 0 0 0", m0_rvalid, m0_rd, m0_err);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    test_back_to_back(9);
  endtask

  task automatic test_misaligned();
    m1_req = 1'b1; m1_addr = 32'h201; m1_dt = DT_HALF;
    push_exp(1'b1, 32'habcdef12, EALIGN);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, mem_dt} !== {1'b1, DT_HALF} || mem_addr !== 32'h201) begin
      n_fail++;
      $display("FAIL misaligned_gnt: got gnt1=%b dt=%0d addr=%h, want 1 1 201", m1_gnt, mem_dt, mem_addr);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_m1_read();
    test_write_then_read();
    test_back_to_back(27);
    test_reset_pending();
    test_misaligned();
    next_cycle();
    next_cycle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
